// File: rtl/rate_out_buffer_pkg.sv
// Shared constants, FSM encoding and sizing helper for the rate output buffer.
package rate_out_buffer_pkg;

    localparam int unsigned DWIDTH_DEF   = 16;
    localparam int unsigned DEPTH_DEF    = 8;
    localparam int unsigned TICK_DIV_DEF = 2083;

    typedef enum logic {
        PREFILL = 1'b0,
        RUN     = 1'b1
    } state_t;

    // Width of an occupancy value able to hold 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rate_out_buffer_sample_fifo.sv
// Single-clock sample FIFO with a separate occupancy counter.
module sample_fifo
    import rate_out_buffer_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned AW     = level_width(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [0:DWIDTH-1] wr_data,
    input  logic              rd_en,
    output logic [0:DWIDTH-1] rd_data,
    output logic [AW:0]       count
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [0:DWIDTH-1] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok_c;
    logic              rd_ok_c;

    // Never overwrite a full FIFO or pop an empty one.
    assign wr_ok_c = wr_en && (count != FULL_CNT);
    assign rd_ok_c = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap modulo DEPTH; occupancy tracked independently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok_c, rd_ok_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok_c) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rate_out_buffer.sv
// Rate output buffer: absorbs bursty filter output and replays it at a fixed tick rate.
// Optional build macro OUT_HOLD_LAST_EN: repeat last sample on underrun instead of silence.
module rate_out_buffer
    import rate_out_buffer_pkg::*;
#(
    parameter int unsigned DWIDTH      = DWIDTH_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned DEPTH_LOG   = level_width(DEPTH) - 1,
    parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
    parameter int unsigned TICK_LOG    = 12,
    parameter int unsigned START_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    output logic                     ack_in,
    input  logic signed [0:DWIDTH-1] data_in,
    output logic signed [0:DWIDTH-1] sample_out,
    output logic                     sample_stb,
    output logic [DEPTH_LOG:0]       level,
    output logic                     underrun
);

    localparam int unsigned LW = DEPTH_LOG + 1;
    localparam logic [LW-1:0]       FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0]       START_LVL = LW'(START_LEVEL);
    localparam logic [TICK_LOG-1:0] TICK_LAST = TICK_LOG'(TICK_DIV - 1);

    state_t             state;
    logic [TICK_LOG-1:0] tick_cnt;
    logic               tick_c;
    logic               wr_en_c;
    logic               rd_en_c;
    logic [0:DWIDTH-1]  head;
    logic [LW-1:0]      count;

    assign tick_c  = (tick_cnt == TICK_LAST);
    assign wr_en_c = req_in && ack_in;
    assign rd_en_c = (state == RUN) && tick_c && (count != '0);
    assign level   = count;

    sample_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (DEPTH_LOG)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_data (data_in),
        .rd_en   (rd_en_c),
        .rd_data (head),
        .count   (count)
    );

    // Free-running output-rate counter, one tick every TICK_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_LOG'(1);
        end
    end

    // Input ack: single-cycle pulse, withheld at full so nothing is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_in <= 1'b0;
        end else begin
            ack_in <= req_in && !ack_in && (count != FULL_LVL);
        end
    end

    // Prefill/run state machine with registered sample output and strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PREFILL;
            sample_out <= '0;
            sample_stb <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            case (state)
                PREFILL: begin
                    if (count >= START_LVL) state <= RUN;
                end
                RUN: begin
                    if (tick_c) begin
                        sample_stb <= 1'b1;
                        if (count != '0) begin
                            sample_out <= head;
                        end else begin
                            underrun <= 1'b1;
`ifdef OUT_HOLD_LAST_EN
                            sample_out <= sample_out;
`else
                            sample_out <= '0;
`endif
                        end
                    end
                end
                default: state <= PREFILL;
            endcase
        end
    end

endmodule
